// File: rtl/game_mode_selector_if.sv
// Menu controller bus: player keys and frame/game strobes in, mode and screen flags out.
// The master side (the board or a bench) drives the keys. The slave side is the menu controller.
interface game_mode_selector_if;
   logic key_up;
   logic key_down;
   logic key_enter;
   logic startOfFrame;
   logic game_over;
   logic mode_sel;
   logic menu_active;
   logic controls_active;
   logic playing;
   logic start_pulse;
   logic highlight_on;

   modport master (
      output key_up, key_down, key_enter, startOfFrame, game_over,
      input  mode_sel, menu_active, controls_active, playing, start_pulse, highlight_on
   );

   modport slave (
      input  key_up, key_down, key_enter, startOfFrame, game_over,
      output mode_sel, menu_active, controls_active, playing, start_pulse, highlight_on
   );
endinterface

// File: rtl/game_mode_selector.sv
// Front-end menu controller.
// It debounces the up/down/enter keys and owns the 1P/2P mode selection.
// It sequences MENU -> CONTROLS -> PLAYING -> MENU.
// It also produces a frame-paced blinking cursor highlight for the menu drawer.
module game_mode_selector #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned BLINK_FRAMES    = 30
) (
   input logic           clk,
   input logic           reset,
   game_mode_selector_if.slave bus
);

   // Key indices into the per-key debounce vectors
   localparam int unsigned K_UP  = 0;
   localparam int unsigned K_DN  = 1;
   localparam int unsigned K_EN  = 2;
   localparam int unsigned NKEYS = 3;

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   typedef enum logic [1:0] {
      S_MENU     = 2'd0,
      S_CONTROLS = 2'd1,
      S_PLAYING  = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // Debounce
   // ---------------------------------------------------------------
   logic [NKEYS-1:0] raw;
   logic [NKEYS-1:0] db_lvl_q, db_lvl_d;
   logic [CW-1:0]    db_cnt_q [NKEYS];
   logic [CW-1:0]    db_cnt_d [NKEYS];
   logic [NKEYS-1:0] key_evt;

   assign raw = {bus.key_enter, bus.key_down, bus.key_up};

   // Per-key stability counter. The event fires in the same cycle the level flips 0->1,
   // so the FSM reacts on the edge that commits the new debounced level.
   always_comb begin
      db_lvl_d = db_lvl_q;
      key_evt  = '0;
      for (int unsigned k = 0; k < NKEYS; k++) begin
         db_cnt_d[k] = '0;
         if (raw[k] != db_lvl_q[k]) begin
            if (db_cnt_q[k] == DB_LAST) begin
               db_lvl_d[k] = raw[k];
               key_evt[k]  = raw[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Debounce state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         db_lvl_q <= '0;
         for (int unsigned k = 0; k < NKEYS; k++) begin
            db_cnt_q[k] <= '0;
         end
      end else begin
         db_lvl_q <= db_lvl_d;
         for (int unsigned k = 0; k < NKEYS; k++) begin
            db_cnt_q[k] <= db_cnt_d[k];
         end
      end
   end

   logic ev_up, ev_dn, ev_en;
   assign ev_up = key_evt[K_UP];
   assign ev_dn = key_evt[K_DN];
   assign ev_en = key_evt[K_EN];

   // ---------------------------------------------------------------
   // Menu FSM
   // ---------------------------------------------------------------
   state_t state_q, state_d;
   logic   mode_sel_q, mode_sel_d;
   logic   start_pulse_q, start_pulse_d;
   logic   menu_active_q, controls_active_q, playing_q;

   // Next state and mode selection.
   // In MENU, enter wins over up/down, and simultaneous up+down cancel out.
   always_comb begin
      state_d       = state_q;
      mode_sel_d    = mode_sel_q;
      start_pulse_d = 1'b0;
      case (state_q)
         S_MENU: begin
            if (ev_en) begin
               state_d = S_CONTROLS;
            end else if (ev_up && !ev_dn) begin
               mode_sel_d = 1'b0;
            end else if (ev_dn && !ev_up) begin
               mode_sel_d = 1'b1;
            end
         end
         S_CONTROLS: begin
            if (ev_en) begin
               state_d       = S_PLAYING;
               start_pulse_d = 1'b1;
            end
         end
         S_PLAYING: begin
            if (bus.game_over) begin
               state_d = S_MENU;
            end
         end
         default: begin
            state_d = S_MENU;
         end
      endcase
   end

   // State, mode and flag registers. The flags are decoded from the next state,
   // so each flag register always matches the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q           <= S_MENU;
         mode_sel_q        <= 1'b0;
         start_pulse_q     <= 1'b0;
         menu_active_q     <= 1'b1;
         controls_active_q <= 1'b0;
         playing_q         <= 1'b0;
      end else begin
         state_q           <= state_d;
         mode_sel_q        <= mode_sel_d;
         start_pulse_q     <= start_pulse_d;
         menu_active_q     <= (state_d == S_MENU);
         controls_active_q <= (state_d == S_CONTROLS);
         playing_q         <= (state_d == S_PLAYING);
      end
   end

   // ---------------------------------------------------------------
   // Cursor blink
   // ---------------------------------------------------------------
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          highlight_q, highlight_d;

   // Count frames only while staying in MENU.
   // Entering MENU or being outside it restarts the blink phase with the highlight lit.
   always_comb begin
      blink_cnt_d = '0;
      highlight_d = 1'b1;
      if (state_q == S_MENU && state_d == S_MENU) begin
         blink_cnt_d = blink_cnt_q;
         highlight_d = highlight_q;
         if (bus.startOfFrame) begin
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               highlight_d = ~highlight_q;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end
      end
   end

   // Blink registers
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_cnt_q <= '0;
         highlight_q <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         highlight_q <= highlight_d;
      end
   end

   assign bus.mode_sel        = mode_sel_q;
   assign bus.menu_active     = menu_active_q;
   assign bus.controls_active = controls_active_q;
   assign bus.playing         = playing_q;
   assign bus.start_pulse     = start_pulse_q;
   assign bus.highlight_on    = highlight_q;

endmodule
